visaccum: RTL and testbench

VISACCUM -- requirements
Module: visaccum

---
 rtl/visaccum.sv | 106 ++++++++++
 tb/tb_visaccum.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/visaccum.sv
// visaccum: ping-pong visibility accumulator summing BLOCKS frames of COUNT beats,
// streaming each completed set out over a valid/ready interface.
module visaccum #(
    parameter int ABITS  = 4,
    parameter int ACCUM  = 24,
    parameter int COUNT  = 64,
    parameter int BLOCKS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic                 frame_i,
    input  logic [ABITS-1:0]     revis_i,
    input  logic [ABITS-1:0]     imvis_i,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic [2*ACCUM-1:0]   m_tdata,
    output logic                 overflow_o,
    output logic                 desync_o
);
    localparam int IW = $clog2(COUNT);
    localparam int BW = BLOCKS > 1 ? $clog2(BLOCKS) : 1;
    localparam int DW = 2 * ACCUM;
    localparam logic [IW-1:0] LAST = IW'(COUNT - 1);
    localparam logic [BW-1:0] BLAST = BW'(BLOCKS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    state_t state, state_nx;
    logic [DW-1:0] mem [2*COUNT];
    logic [IW-1:0] idx, ridx, cur_idx;
    logic [BW-1:0] blk, cur_blk;
    logic abank, s1_v, s1_first, s1_last;
    logic [IW:0] s1_addr, addr_in;
    logic [DW-1:0] s1_d, rd_q, wdata, ext;
    logic desync, ignore, take, hs, ridle, swap;

    always_comb begin
        desync   = valid_i && frame_i && idx != '0;
        ignore   = desync_o && !frame_i && idx == '0 && blk == '0;
        take     = valid_i && !ignore;
        cur_idx  = desync ? '0 : idx;
        cur_blk  = desync ? '0 : blk;
        hs       = m_tvalid && m_tready;
        ridle    = state == IDLE || (hs && ridx == LAST);
        swap     = s1_v && s1_last && ridle;
        // a beat arriving in the swap cycle already belongs to the new bank
        addr_in  = {swap ? !abank : abank, cur_idx};
        ext      = {{(ACCUM-ABITS){revis_i[ABITS-1]}}, revis_i,
                    {(ACCUM-ABITS){imvis_i[ABITS-1]}}, imvis_i};
        wdata    = s1_first ? s1_d : {s1_d[DW-1:ACCUM] + rd_q[DW-1:ACCUM],
                                      s1_d[ACCUM-1:0] + rd_q[ACCUM-1:0]};
        m_tvalid = state == SEND;
        m_tlast  = m_tvalid && ridx == LAST;
        state_nx = swap ? FETCH :
                   state == FETCH ? SEND :
                   state == SEND && !hs ? SEND :
                   state == SEND && ridx != LAST ? FETCH : IDLE;
    end

    always_ff @(posedge clock) begin
        if (s1_v)
            mem[s1_addr] <= wdata;
        rd_q <= (s1_v && s1_addr == addr_in) ? wdata : mem[addr_in];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            blk        <= '0;
            abank      <= 1'b0;
            s1_v       <= 1'b0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            s1_addr    <= '0;
            s1_d       <= '0;
            state      <= IDLE;
            ridx       <= '0;
            m_tdata    <= '0;
            overflow_o <= 1'b0;
            desync_o   <= 1'b0;
        end else begin
            s1_v <= take;
            if (take) begin
                s1_addr  <= addr_in;
                s1_first <= cur_blk == '0;
                s1_last  <= cur_idx == LAST && cur_blk == BLAST;
                s1_d     <= ext;
                idx      <= cur_idx == LAST ? '0 : cur_idx + 1'b1;
                blk      <= cur_idx != LAST ? cur_blk : cur_blk == BLAST ? '0 : cur_blk + 1'b1;
            end
            if (desync)
                desync_o <= 1'b1;
            if (s1_v && s1_last && !ridle)
                overflow_o <= 1'b1;
            if (swap)
                abank <= !abank;
            state <= state_nx;
            if (hs)
                ridx <= ridx == LAST ? '0 : ridx + 1'b1;
            if (state == FETCH)
                m_tdata <= mem[{!abank, ridx}];
        end
    end
endmodule

// File: tb/tb_visaccum.sv
// tb_visaccum: directed scoreboard bench for visaccum; u0 is the COUNT=4/BLOCKS=2
// build, u1 the narrow ACCUM=6/BLOCKS=8 build used to exercise wraparound.
module tb_visaccum;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic valid = 0, frame = 0, ready = 1;
    logic [3:0] re = 0, im = 0;
    logic tvalid, tlast, ovf, dsy;
    logic [47:0] tdata;

    logic valid1 = 0, frame1 = 0, ready1 = 1;
    logic [3:0] re1 = 0, im1 = 0;
    logic tvalid1, tlast1, ovf1, dsy1;
    logic [11:0] tdata1;

    visaccum #(.ABITS(4), .ACCUM(24), .COUNT(4), .BLOCKS(2)) u0 (
        .clock(clk), .reset(rst), .valid_i(valid), .frame_i(frame),
        .revis_i(re), .imvis_i(im), .m_tvalid(tvalid), .m_tready(ready),
        .m_tlast(tlast), .m_tdata(tdata), .overflow_o(ovf), .desync_o(dsy));

    visaccum #(.ABITS(4), .ACCUM(6), .COUNT(4), .BLOCKS(8)) u1 (
        .clock(clk), .reset(rst), .valid_i(valid1), .frame_i(frame1),
        .revis_i(re1), .imvis_i(im1), .m_tvalid(tvalid1), .m_tready(ready1),
        .m_tlast(tlast1), .m_tdata(tdata1), .overflow_o(ovf1), .desync_o(dsy1));

    logic [48:0] q0[$];
    logic [12:0] q1[$];
    int n_cmp = 0;
    int n_err = 0;
    int ra[2][4];
    int ia[2][4];
    int n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every cycle advance goes through here so the output beats are scored at the negedge.
    task automatic tick;
        @(negedge clk);
        if (tvalid) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL u0_extra: observed beat %0h expected none", {tlast, tdata});
            end else begin
                chk("u0_beat", {15'd0, tlast, tdata}, {15'd0, q0[0]});
                if (ready) void'(q0.pop_front());
            end
        end
        if (tvalid1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL u1_extra: observed beat %0h expected none", {tlast1, tdata1});
            end else begin
                chk("u1_beat", {51'd0, tlast1, tdata1}, {51'd0, q1[0]});
                if (ready1) void'(q1.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic f, input int r, input int i);
        valid = 1;
        frame = f;
        re = 4'(r);
        im = 4'(i);
        tick();
    endtask

    task automatic idle(input int cycles);
        valid = 0;
        frame = 0;
        repeat (cycles) tick();
    endtask

    task automatic gen_rand;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 4; i++) begin
                ra[f][i] = int'($urandom_range(0, 15)) - 8;
                ia[f][i] = int'($urandom_range(0, 15)) - 8;
            end
    endtask

    task automatic send_set(input bit push);
        if (push)
            for (int i = 0; i < 4; i++)
                q0.push_back({i == 3, 24'(ra[0][i] + ra[1][i]), 24'(ia[0][i] + ia[1][i])});
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 4; i++)
                beat(i == 0, ra[f][i], ia[f][i]);
        valid = 0;
        frame = 0;
    endtask

    task automatic drain;
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 300) begin
            tick();
            k++;
        end
        chk("drain_timeout", 64'(q0.size() + q1.size()), 0);
        idle(4);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_dsy", dsy, 0);
        rst = 0;
        idle(2);

        ra[0] = '{1, 2, -8, 3};
        ia[0] = '{-1, 0, 7, 3};
        ra[1] = ra[0];
        ia[1] = ia[0];
        send_set(1);
        drain();
        chk("basic_ovf", ovf, 0);
        chk("basic_dsy", dsy, 0);

        // back-to-back sets: second swap lands on the final readout handshake
        gen_rand();
        send_set(1);
        gen_rand();
        send_set(1);
        n = 0;
        while (q0.size() > 4 && n < 40) begin
            tick();
            n++;
        end
        n = 0;
        while (!tvalid && n < 10) begin
            tick();
            n++;
        end
        chk("coincide_latency", 64'(n <= 3), 1);
        drain();
        chk("coincide_ovf", ovf, 0);

        ready = 0;
        gen_rand();
        send_set(1);
        n = 0;
        while (!tvalid && n < 10) begin
            tick();
            n++;
        end
        chk("stall_tvalid", tvalid, 1);
        gen_rand();
        send_set(0);
        idle(12);
        chk("stall_ovf", ovf, 1);
        ready = 1;
        drain();

        beat(1, 5, 5);
        beat(0, -3, 6);
        gen_rand();
        send_set(1);
        idle(1);
        chk("desync_flag", dsy, 1);
        drain();
        beat(0, 7, 7);
        gen_rand();
        send_set(1);
        drain();

        ready = 0;
        gen_rand();
        send_set(1);
        n = 0;
        while (!tvalid && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < 3; i++)
            beat(i == 0, 3, -2);
        rst = 1;
        #1;
        chk("mid_rst_tvalid", tvalid, 0);
        chk("mid_rst_tlast", tlast, 0);
        chk("mid_rst_tdata", tdata, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_dsy", dsy, 0);
        q0.delete();
        idle(2);
        rst = 0;
        ready = 1;
        idle(2);
        gen_rand();
        send_set(1);
        drain();

        for (int i = 0; i < 4; i++)
            q1.push_back({i == 3, 6'h38, 6'h00});
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 4; i++) begin
                valid1 = 1;
                frame1 = (i == 0);
                re1 = 4'd7;
                im1 = 4'h8;
                tick();
            end
        valid1 = 0;
        frame1 = 0;
        drain();
        chk("wrap_ovf", ovf1, 0);
        chk("wrap_dsy", dsy1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
